// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, base address, word count, LE data words, checksum -> IMEM writes.
// Write strobe one cycle after the 4th byte of each word; in_ready drops only in that write cycle.
module imem_loader #(
  parameter int          ADDR_W  = 14,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [3:0]  REGION  = 4'b0001,
  parameter int          TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [3:0]        imem_wmask,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [31:0]       words_written
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CKSUM = 3'd5;

  logic [2:0]    state;
  logic [1:0]    byte_idx;
  logic [23:0]   shift_q;
  logic [31:0]   remaining;
  logic [7:0]    cksum;
  logic          range_bad;
  logic [TW-1:0] idle_cnt;

  logic        xfer;
  logic        in_frame;
  logic        timed_out;
  logic [31:0] field;

  assign xfer      = in_valid & in_ready;
  assign in_frame  = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CKSUM);
  assign timed_out = in_frame && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
  // Header fields arrive LSB first; the current byte completes the top of the word.
  assign field     = {in_data, shift_q};

  assign in_ready   = rst && (state != S_WRITE);
  assign imem_we    = (state == S_WRITE) && !range_bad;
  assign imem_wmask = imem_we ? 4'hF : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      byte_idx      <= 2'd0;
      shift_q       <= 24'd0;
      remaining     <= 32'd0;
      cksum         <= 8'd0;
      range_bad     <= 1'b0;
      idle_cnt      <= '0;
      imem_addr     <= '0;
      imem_din      <= 32'd0;
      core_hold     <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      words_written <= 32'd0;
    end else begin
      load_done <= 1'b0;

      if (in_frame && !xfer) idle_cnt <= idle_cnt + 1'b1;
      else                   idle_cnt <= '0;

      if (timed_out) begin
        state     <= S_IDLE;
        load_err  <= 1'b1;
        core_hold <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (xfer && (in_data == SYNC)) begin
              state         <= S_ADDR;
              load_err      <= 1'b0;
              words_written <= 32'd0;
              cksum         <= 8'd0;
              byte_idx      <= 2'd0;
              range_bad     <= 1'b0;
              core_hold     <= 1'b1;
            end
          end
          S_ADDR: begin
            if (xfer) begin
              shift_q  <= field[31:8];
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                state     <= S_LEN;
                imem_addr <= field[ADDR_W+1:2];
                range_bad <= (field[31:28] != REGION) || (field[1:0] != 2'b00);
              end
            end
          end
          S_LEN: begin
            if (xfer) begin
              shift_q  <= field[31:8];
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                remaining <= field;
                state     <= (field == 32'd0) ? S_CKSUM : S_DATA;
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              imem_din[{byte_idx, 3'b000} +: 8] <= in_data;
              cksum    <= cksum + in_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) state <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (!range_bad) words_written <= words_written + 32'd1;
            imem_addr <= imem_addr + 1'b1;
            remaining <= remaining - 32'd1;
            state     <= (remaining == 32'd1) ? S_CKSUM : S_DATA;
          end
          S_CKSUM: begin
            if (xfer) begin
              state     <= S_IDLE;
              core_hold <= 1'b0;
              if ((in_data == cksum) && !range_bad) load_done <= 1'b1;
              else                                  load_err  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole frames with hand-derived results, plus timeout and reset sequences.
module tb_imem_loader;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [3:0]        imem_wmask;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              core_hold;
  logic              load_done;
  logic              load_err;
  logic [31:0]       words_written;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_wmask(imem_wmask), .imem_addr(imem_addr), .imem_din(imem_din),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_dat_q[$];
  int done_cnt, rdy_low, hold_bad, mask_bad, hold_drop;
  bit in_frame_tb = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (imem_we) begin
        wr_addr_q.push_back(imem_addr);
        wr_dat_q.push_back(imem_din);
        if (imem_wmask != 4'hF) mask_bad++;
      end else if (imem_wmask != 4'h0) mask_bad++;
      if (load_done) begin
        done_cnt++;
        if (core_hold) hold_bad++;
      end
      if (!in_ready) rdy_low++;
      if (in_frame_tb && !core_hold) hold_drop++;
    end
  end

  int byte_seq = 0;

  // While in_valid is low in_data carries the SYNC value, which must be ignored.
  task automatic send_b(input logic [7:0] b, input bit stalled);
    int guard;
    if (stalled) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      repeat ((byte_seq % 5) + 1) @(posedge clk);
      #1;
    end
    byte_seq++;
    in_data  = b;
    in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        checks++;
        fails++;
        $display("FAIL handshake_timeout byte=0x%02h actual=no_ready required=ready", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0]       base;
    int                n;
    logic [31:0]       w0;
    logic [31:0]       w1;
    logic [7:0]        ck_xor;
    bit                garbage;
    bit                stall;
    int                exp_wr;
    logic [ADDR_W-1:0] exp_a0;
    logic [ADDR_W-1:0] exp_a1;
    bit                exp_done;
    bit                exp_err;
    int                exp_ww;
  } vec_t;

  vec_t vecs[8];

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_dat_q.delete();
    done_cnt = 0; rdy_low = 0; hold_bad = 0; mask_bad = 0; hold_drop = 0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [7:0] ck;
    logic [31:0] word;
    clear_mon();
    ck = 8'h00;
    if (v.garbage) begin
      send_b(8'h00, v.stall);
      send_b(8'hFF, v.stall);
      check($sformatf("v%0d_garbage_no_hold", id), {31'd0, core_hold}, 32'd0);
    end
    send_b(8'hA5, v.stall);
    check($sformatf("v%0d_sync_hold", id), {31'd0, core_hold}, 32'd1);
    check($sformatf("v%0d_sync_err_clr", id), {31'd0, load_err}, 32'd0);
    in_frame_tb = 1'b1;
    for (int i = 0; i < 4; i++) send_b(v.base[8*i +: 8], v.stall);
    for (int i = 0; i < 4; i++) begin
      word = v.n;
      send_b(word[8*i +: 8], v.stall);
    end
    for (int w = 0; w < v.n; w++) begin
      word = (w == 0) ? v.w0 : v.w1;
      for (int i = 0; i < 4; i++) begin
        send_b(word[8*i +: 8], v.stall);
        ck = ck + word[8*i +: 8];
      end
    end
    send_b(ck ^ v.ck_xor, v.stall);
    in_frame_tb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("v%0d_nwrites", id), wr_addr_q.size(), v.exp_wr);
    if (wr_addr_q.size() >= v.exp_wr) begin
      for (int j = 0; j < v.exp_wr; j++) begin
        check($sformatf("v%0d_addr%0d", id, j), {18'd0, wr_addr_q[j]}, {18'd0, (j == 0) ? v.exp_a0 : v.exp_a1});
        check($sformatf("v%0d_data%0d", id, j), wr_dat_q[j], (j == 0) ? v.w0 : v.w1);
      end
    end
    check($sformatf("v%0d_done_pulses", id), done_cnt, v.exp_done ? 32'd1 : 32'd0);
    check($sformatf("v%0d_load_err", id), {31'd0, load_err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_words_written", id), words_written, v.exp_ww);
    check($sformatf("v%0d_hold_end", id), {31'd0, core_hold}, 32'd0);
    check($sformatf("v%0d_ready_low_cycles", id), rdy_low, v.n);
    check($sformatf("v%0d_hold_with_done", id), hold_bad, 32'd0);
    check($sformatf("v%0d_hold_dropout", id), hold_drop, 32'd0);
    check($sformatf("v%0d_wmask", id), mask_bad, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_wmask"}, {28'd0, imem_wmask}, 32'd0);
    check({tag, "_addr"}, {18'd0, imem_addr}, 32'd0);
    check({tag, "_din"}, imem_din, 32'd0);
    check({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    check({tag, "_ww"}, words_written, 32'd0);
  endtask

  initial begin
    //          base          n  w0            w1            ckx    gb stl wr a0        a1        dn er ww
    vecs[0] = '{32'h10000000, 2, 32'h00000013, 32'h00100093, 8'h00, 0, 0, 2, 14'h0000, 14'h0001, 1, 0, 2};
    vecs[1] = '{32'h10000000, 2, 32'h00000013, 32'h00100093, 8'h01, 0, 0, 2, 14'h0000, 14'h0001, 0, 1, 2};
    vecs[2] = '{32'h20000000, 1, 32'hDEADBEEF, 32'h00000000, 8'h00, 0, 0, 0, 14'h0000, 14'h0000, 0, 1, 0};
    vecs[3] = '{32'h1000FFFC, 2, 32'h11111111, 32'h22222222, 8'h00, 0, 0, 2, 14'h3FFF, 14'h0000, 1, 0, 2};
    vecs[4] = '{32'h10000000, 2, 32'h00000013, 32'h00100093, 8'h00, 1, 1, 2, 14'h0000, 14'h0001, 1, 0, 2};
    vecs[5] = '{32'h10000040, 0, 32'h00000000, 32'h00000000, 8'h00, 0, 0, 0, 14'h0000, 14'h0000, 1, 0, 0};
    vecs[6] = '{32'h10000002, 1, 32'h01020304, 32'h00000000, 8'h00, 0, 0, 0, 14'h0000, 14'h0000, 0, 1, 0};
    vecs[7] = '{32'h10000100, 1, 32'hA5A5A5A5, 32'h00000000, 8'h00, 0, 1, 1, 14'h0040, 14'h0000, 1, 0, 1};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    #1;
    check("post_reset_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Stall mid-word: 15 idle edges keep the frame alive, the 16th aborts it.
    clear_mon();
    send_b(8'hA5, 0);
    send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h10, 0);
    send_b(8'h02, 0); send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h00, 0);
    send_b(8'h13, 0); send_b(8'h00, 0);
    repeat (14) @(posedge clk);
    #1;
    check("to_still_held", {31'd0, core_hold}, 32'd1);
    check("to_no_err_yet", {31'd0, load_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("to_hold_dropped", {31'd0, core_hold}, 32'd0);
    check("to_err", {31'd0, load_err}, 32'd1);
    check("to_no_write", wr_addr_q.size(), 32'd0);
    check("to_no_done", done_cnt, 32'd0);
    run_vec(10, vecs[0]);

    // Reset after one word has already been written.
    clear_mon();
    send_b(8'hA5, 0);
    send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h10, 0);
    send_b(8'h02, 0); send_b(8'h00, 0); send_b(8'h00, 0); send_b(8'h00, 0);
    send_b(8'hDD, 0); send_b(8'hCC, 0); send_b(8'hBB, 0); send_b(8'hAA, 0);
    send_b(8'h44, 0); send_b(8'h33, 0);
    check("mid_ww_before_rst", words_written, 32'd1);
    check("mid_din_before_rst", imem_din, 32'hAA_BB_33_44);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    check("midrst_writes", wr_addr_q.size(), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_vec(11, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
